// File: rtl/mig_seq.sv
// mig_seq: sequential majority-inverter graph evaluator.
// One shared 3-input majority unit is stepped through up to NODES configured nodes
// for each of the 128 input vectors, building the full truth table of the output node.
module mig_seq #(
    parameter int unsigned NODES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [14:0]  cfg_data,
    input  logic [2:0]   last_node,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic [7:0]   ones
);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e            state_q, state_d;
    logic [14:0]       cfg_q [NODES];
    logic [2:0]        last_q;
    logic [6:0]        v_q;
    logic [2:0]        n_q;
    logic [NODES-1:0]  w_q;
    logic [127:0]      tt_q;
    logic [7:0]        ones_q;

    logic [14:0]       entry;
    logic              op_a, op_b, op_c;
    logic              result;
    logic              last_step;

    // Operand field {comp, sel}: sel 0 is constant 0, 1..7 pick x0..x6, 8..15 pick w0..w7.
    function automatic logic operand(input logic [4:0] f, input logic [6:0] x,
                                     input logic [7:0] w);
        logic       val;
        logic [2:0] idx;
        idx = f[2:0] - 3'd1;
        if (f[3]) begin
            val = w[f[2:0]];
        end else if (f[2:0] == 3'd0) begin
            val = 1'b0;
        end else begin
            val = x[idx];
        end
        return val ^ f[4];
    endfunction

    // Evaluate node n for the current vector with the shared majority unit.
    // Unwritten w slots are still cleared, so forward references read 0.
    always_comb begin
        entry     = cfg_q[n_q];
        op_a      = operand(entry[4:0], v_q, w_q);
        op_b      = operand(entry[9:5], v_q, w_q);
        op_c      = operand(entry[14:10], v_q, w_q);
        result    = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        last_step = (n_q == last_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StEval;
            StEval: if (last_step && (v_q == 7'd127)) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded directly from the state.
    always_comb begin
        busy = (state_q == StEval);
        done = (state_q == StDone);
    end

    // Configuration table; writes are locked out during a sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NODES); i++) cfg_q[i] <= '0;
        end else if (cfg_we && (state_q != StEval)) begin
            cfg_q[cfg_addr] <= cfg_data;
        end
    end

    // Sweep datapath: node stepping, vector stepping and result accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= '0;
            v_q    <= '0;
            n_q    <= '0;
            w_q    <= '0;
            tt_q   <= '0;
            ones_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        last_q <= last_node;
                        v_q    <= '0;
                        n_q    <= '0;
                        w_q    <= '0;
                        tt_q   <= '0;
                        ones_q <= '0;
                    end
                end
                StEval: begin
                    if (last_step) begin
                        tt_q[v_q] <= result;
                        // At most 128 increments, so 8 bits never wrap.
                        ones_q    <= ones_q + {7'd0, result};
                        w_q       <= '0;
                        n_q       <= '0;
                        if (v_q != 7'd127) v_q <= v_q + 7'd1;
                    end else begin
                        w_q[n_q] <= result;
                        n_q      <= n_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tt   = tt_q;
    assign ones = ones_q;

endmodule

// File: tb/tb_mig_seq.sv
// Scoreboard bench for mig_seq: the stimulus process queues expected sweep results,
// the monitor pops and compares them whenever done pulses.
module tb_mig_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [14:0]  cfg_data;
    logic [2:0]   last_node;
    logic         start;
    logic         busy;
    logic         done;
    logic [127:0] tt;
    logic [7:0]   ones;

    mig_seq #(.NODES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .last_node (last_node),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .tt        (tt),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   ones;
        int           lat;
        int           busyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   busy_cnt = 0;

    localparam logic [127:0] TtAlt  = {64{2'b10}};
    localparam logic [127:0] TtMaj  = {16{8'hE8}};
    localparam logic [127:0] TtAnd  = {1'b1, 127'd0};
    localparam logic [127:0] TtOnes = {128{1'b1}};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] fld(input logic comp, input logic [3:0] sel);
        return {comp, sel};
    endfunction

    function automatic logic [14:0] node(input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks each completed sweep against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 128'(done), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("tt", tt, e.tt);
                    chk("ones", 128'(ones), 128'(e.ones));
                    chk("done_latency", 128'(cyc - start_cyc), 128'(e.lat));
                    chk("busy_cycles", 128'(busy_cnt), 128'(e.busyc));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic cfg_write(input logic [2:0] addr, input logic [14:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle config write) and queue the expectation.
    task automatic run(input logic [2:0] l, input logic [127:0] ett, input logic [7:0] eones,
                       input logic wr, input logic [2:0] addr, input logic [14:0] data);
        exp_t e;
        @(negedge clk);
        last_node = l;
        start     = 1'b1;
        cfg_we    = wr;
        cfg_addr  = addr;
        cfg_data  = data;
        start_cyc = cyc;
        e.tt      = ett;
        e.ones    = eones;
        e.busyc   = 128 * (int'(l) + 1);
        e.lat     = e.busyc + 1;
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while (q.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (q.size() != 0) begin
            chk("sweep_timeout", 128'(q.size()), 128'(0));
            q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        last_node = '0;
        start     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_tt", tt, 128'(0));
        chk("rst_ones", 128'(ones), 128'(0));
        rst_n = 1'b1;

        // Identity: MAJ(x0, 0, 1) = x0.
        cfg_write(3'd0, node(fld(0, 4'd1), fld(0, 4'd0), fld(1, 4'd0)));
        run(3'd0, TtAlt, 8'd64, 1'b0, 3'd0, 15'd0);
        wait_drain(400);
        repeat (5) @(negedge clk);
        chk("tt_hold", tt, TtAlt);
        chk("ones_hold", 128'(ones), 128'(64));

        // Constant 0 and constant 1.
        cfg_write(3'd0, node(fld(0, 4'd0), fld(0, 4'd0), fld(0, 4'd0)));
        run(3'd0, 128'd0, 8'd0, 1'b0, 3'd0, 15'd0);
        wait_drain(400);
        cfg_write(3'd0, node(fld(1, 4'd0), fld(1, 4'd0), fld(1, 4'd0)));
        run(3'd0, TtOnes, 8'h80, 1'b0, 3'd0, 15'd0);
        wait_drain(400);

        // 7-input AND chain over six nodes.
        cfg_write(3'd0, node(fld(0, 4'd1), fld(0, 4'd2), fld(0, 4'd0)));
        for (int k = 1; k <= 5; k++) begin
            cfg_write(3'(k), node(fld(0, 4'(8 + k - 1)), fld(0, 4'(k + 2)), fld(0, 4'd0)));
        end
        run(3'd5, TtAnd, 8'd1, 1'b0, 3'd0, 15'd0);
        wait_drain(1500);

        // Majority of x0,x1,x2 written in the same cycle as start.
        run(3'd0, TtMaj, 8'd64, 1'b1, 3'd0, node(fld(0, 4'd1), fld(0, 4'd2), fld(0, 4'd3)));
        wait_drain(400);

        // Start and config write mid-sweep must both be ignored.
        run(3'd0, TtMaj, 8'd64, 1'b0, 3'd0, 15'd0);
        repeat (9) @(negedge clk);
        start     = 1'b1;
        last_node = 3'd3;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_data  = node(fld(1, 4'd0), fld(1, 4'd0), fld(1, 4'd0));
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        wait_drain(400);
        run(3'd0, TtMaj, 8'd64, 1'b0, 3'd0, 15'd0);
        wait_drain(400);

        // Reset mid-sweep aborts silently; start held during reset is ignored.
        @(negedge clk);
        last_node = 3'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("busy_before_abort", 128'(busy), 128'(1));
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_tt", tt, 128'(0));
        chk("abort_ones", 128'(ones), 128'(0));
        @(negedge clk);
        chk("abort_no_restart", 128'(busy), 128'(0));
        repeat (200) @(negedge clk);

        // Fresh sweep after reset (config table was cleared).
        cfg_write(3'd0, node(fld(0, 4'd1), fld(0, 4'd0), fld(1, 4'd0)));
        run(3'd0, TtAlt, 8'd64, 1'b0, 3'd0, 15'd0);
        wait_drain(400);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
